serial_adder_32bit: RTL and testbench
=====================================

// Module: serial_adder_32bit
// PURPOSE
//  Multi-cycle adder: a + b + cin, CHUNK bits per clock, LSB chunk first.
//  Operands are latched on start and held internally; the carry is kept in a flop between chunks.
//  Additive counterpart of the 32-bit ripple subtractor; shares the ALU operand buses.
//  Trades latency for a short carry path in timing-critical ALU builds.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  CHUNK   8  bits added per cycle; must divide WIDTH; N = WIDTH/CHUNK chunk cycles
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request; sampled only in IDLE or DONE
//  a         in   WIDTH  operand A, sampled with start
//  b         in   WIDTH  operand B, sampled with start
//  cin       in   1      initial carry-in, sampled with start
//  busy      out  1      high while chunks are being added
//  done      out  1      one-cycle pulse; sum/cout/overflow valid
//  sum       out  WIDTH  result; held until the next accepted start
//  cout      out  1      final carry out of bit WIDTH-1
//  overflow  out  1      signed overflow (see CONFIGURATION)
// BEHAVIOUR
//  Reset: rst=1 at an edge -> state IDLE, busy=0, done=0, sum=0, cout=0,
//   overflow=0, chunk counter=0, carry flop=0. Reset has priority over all
//   inputs, including mid-BUSY; a partial result is discarded.
//  FSM: IDLE -start-> BUSY; BUSY -(count==N-1)-> DONE; DONE -start-> BUSY;
//   DONE -!start-> IDLE.
//  Accept edge (start=1 in IDLE/DONE):
//   - latch a, b, cin
//   - count=0, sum=0, busy=1, done=0
//  BUSY edge, chunk k=count:
//   - {c,s} = a[k*CHUNK+:CHUNK] + b[k*CHUNK+:CHUNK] + carry (CHUNK+1-bit add)
//   - sum[k*CHUNK+:CHUNK]=s, carry=c, count=count+1
//  Last chunk (count==N-1):
//   - cout=c, busy=0, done=1 for exactly one cycle
//  Latency: start sampled at edge t -> done high in the cycle after edge t+N.
//   WIDTH=32, CHUNK=8: 4 cycles. Throughput: one op per N+1 cycles;
//   back-to-back via start held in DONE.
//  start while BUSY: ignored, no effect on the operation in flight.
//  start in DONE: accepted; done drops the next cycle.
//  Arithmetic: unsigned modulo 2^WIDTH; cout is the true carry out.
//  Outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  SERIAL_ADD_OVF_EN defined:
//   - overflow = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), using latched operands
//   - set with done, held with sum
//  SERIAL_ADD_OVF_EN undefined:
//   - overflow port present, tied to 0, no logic
// TESTING
//  1. a=FFFFFFFF b=00000001 cin=0 start -> busy 4 cyc; done; sum=0 cout=1
//  2. a=7FFFFFFF b=00000001 cin=0 -> sum=80000000 cout=0;
//     overflow=1 (OVF_EN) else 0
//  3. a=0 b=0 cin=1 -> sum=00000001 cout=0; then 12345678+0FEDCBA8 cin=0
//     -> sum=22222220 cout=0
//  4. start pulses with new operands on each BUSY cycle -> ignored;
//     result equals first operands
//  5. rst=1 at 2nd BUSY cycle -> next cycle busy=0 done=0 sum=0 cout=0;
//     no done pulse follows
//  6. start held high across DONE -> second op accepted in DONE;
//     done pulses every 5 cycles; CHUNK=1 -> latency 32

Source files
------------

// File: rtl/serial_adder_32bit.sv
// serial_adder_32bit: multi-cycle adder computing a + b + cin, CHUNK bits per
// clock, LSB chunk first. Operands are latched on an accepted start and the
// inter-chunk carry lives in a flop, so the critical path is one CHUNK-bit add.
// Optional feature macro: SERIAL_ADD_OVF_EN enables the signed-overflow flag;
// without it the overflow port is tied low.
// CHUNK must divide WIDTH; N = WIDTH/CHUNK chunk cycles per operation.

module serial_adder_32bit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int            N    = WIDTH / CHUNK;
    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    count_q;

    logic             accept, last;
    logic [CHUNK-1:0] a_chunk, b_chunk, s;
    logic             c;
    int               idx;

    // Decode accept/last and add the current chunk with the stored carry.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        accept  = start && (state == IDLE || state == DONE);
        last    = (state == BUSY) && (count_q == LAST);
        idx     = int'(count_q) * CHUNK;
        a_chunk = a_q[idx +: CHUNK];
        b_chunk = b_q[idx +: CHUNK];
        {c, s}  = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK + 1)'(carry_q);
    end

    // Next-state logic: start is only honoured in IDLE or DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (count_q == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand holding registers, loaded only on an accepted start.
    always_ff @(posedge clk) begin
        // NOTE: operands are not reset; they are always written before BUSY can read them.
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Chunk datapath: carry flop, chunk counter, result and carry-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            carry_q <= cin;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (state == BUSY) begin
            sum_q[idx +: CHUNK] <= s;
            carry_q             <= c;
            count_q             <= last ? '0 : count_q + 1'b1;
            if (last) cout_q <= c;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // Signed overflow from latched operand signs and the final sum MSB.
    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (accept)
            ovf_q <= 1'b0;
        else if (last)
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s[CHUNK-1] != a_q[WIDTH-1]);
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign busy = (state == BUSY);
    assign done = (state == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_32bit.sv
// Directed testbench for serial_adder_32bit: default CHUNK=8 instance plus a
// CHUNK=1 instance for the 32-cycle latency case. Honours SERIAL_ADD_OVF_EN.

module tb_serial_adder_32bit;

`ifdef SERIAL_ADD_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [31:0] a_in, b_in;
    logic        cin_in;

    logic        busy0, done0, cout0, ovf0;
    logic [31:0] sum0;
    logic        busy1, done1, cout1, ovf1;
    logic [31:0] sum1;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    serial_adder_32bit #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a_in), .b(b_in), .cin(cin_in),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .overflow(ovf0)
    );

    serial_adder_32bit #(.WIDTH(32), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a_in), .b(b_in), .cin(cin_in),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One operation on dut0 with start pulsed for a single cycle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic [31:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        int  nbusy;
        bit  got;
        @(negedge clk);
        a_in = a; b_in = b; cin_in = ci; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done0) got = 1'b1;
            else begin
                if (busy0) nbusy++;
                @(negedge clk);
            end
        end
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " busy_cycles"}, 32'(nbusy), 32'd4);
        check({tag, " sum"}, sum0, exp_sum);
        check({tag, " cout"}, 32'(cout0), 32'(exp_cout));
        check({tag, " ovf"}, 32'(ovf0), 32'(exp_ovf));
        @(negedge clk);
        check({tag, " done_drop"}, 32'(done0), 32'd0);
    endtask

    initial begin
        int nbusy;
        int cyc;
        int first_done, second_done;
        bit got;

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        a_in = '0; b_in = '0; cin_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy0), 32'd0);
        check("rst done", 32'(done0), 32'd0);
        check("rst sum", sum0, 32'd0);
        check("rst cout", 32'(cout0), 32'd0);
        check("rst ovf", 32'(ovf0), 32'd0);
        check("rst busy1", 32'(busy1), 32'd0);
        rst = 1'b0;

        // Basic vectors
        run_op("t1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("t2", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, OVF_EN);
        run_op("t3a", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
        run_op("t3b", 32'h1234_5678, 32'h0FED_CBA8, 1'b0, 32'h2222_2220, 1'b0, 1'b0);

        // start pulses during BUSY with new operands are ignored
        @(negedge clk);
        a_in = 32'h1111_1111; b_in = 32'h2222_2222; cin_in = 1'b0; start0 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            a_in = 32'hA5A5_0000 + 32'(k); b_in = 32'h0F0F_0000 + 32'(k); cin_in = 1'b1;
            start0 = 1'b1;
        end
        @(negedge clk);
        start0 = 1'b0;
        check("t4 done", 32'(done0), 32'd1);
        check("t4 sum", sum0, 32'h3333_3333);
        check("t4 cout", 32'(cout0), 32'd0);
        @(negedge clk);
        check("t4 done_drop", 32'(done0), 32'd0);
        check("t4 busy_idle", 32'(busy0), 32'd0);

        // Reset in the 2nd BUSY cycle discards the partial result
        @(negedge clk);
        a_in = 32'h1234_5678; b_in = 32'h1111_1111; cin_in = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        check("t5 partial", sum0, 32'h0000_0089);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5 busy", 32'(busy0), 32'd0);
        check("t5 done", 32'(done0), 32'd0);
        check("t5 sum", sum0, 32'd0);
        check("t5 cout", 32'(cout0), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done0) got = 1'b1;
        end
        check("t5 no_done", 32'(got), 32'd0);

        // Back-to-back via start held across DONE
        @(negedge clk);
        a_in = 32'h8000_0000; b_in = 32'h8000_0000; cin_in = 1'b0; start0 = 1'b1;
        first_done = -1; second_done = -1;
        for (cyc = 1; cyc <= 20 && second_done < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                a_in = 32'h0000_0005; b_in = 32'h0000_000A; cin_in = 1'b1;
            end
            if (done0 && first_done < 0) begin
                first_done = cyc;
                check("t6 sum1", sum0, 32'h0000_0000);
                check("t6 cout1", 32'(cout0), 32'd1);
                check("t6 ovf1", 32'(ovf0), 32'(OVF_EN));
            end else if (done0) begin
                second_done = cyc;
                start0 = 1'b0;
                check("t6 sum2", sum0, 32'h0000_0010);
                check("t6 cout2", 32'(cout0), 32'd0);
            end else if (first_done > 0 && cyc == first_done + 1) begin
                check("t6 redo_busy", 32'(busy0), 32'd1);
            end
        end
        start0 = 1'b0;
        check("t6 first_at", 32'(first_done), 32'd5);
        check("t6 period", 32'(second_done - first_done), 32'd5);
        @(negedge clk);
        check("t6 done_drop", 32'(done0), 32'd0);

        // CHUNK=1 instance: 32 busy cycles
        @(negedge clk);
        a_in = 32'hFFFF_FFFF; b_in = 32'h0000_0001; cin_in = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (done1) got = 1'b1;
            else begin
                if (busy1) nbusy++;
                @(negedge clk);
            end
        end
        check("c1 done_seen", 32'(got), 32'd1);
        check("c1 busy_cycles", 32'(nbusy), 32'd32);
        check("c1 sum", sum1, 32'h0000_0000);
        check("c1 cout", 32'(cout1), 32'd1);
        check("c1 ovf", 32'(ovf1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
